// File: rtl/systolic_result_collector_pkg.sv
// Shared definitions for the systolic array result path: default geometry,
// the packed result-row type and the sticky status flags.
package systolic_result_collector_pkg;

  localparam int DEFAULT_N_COLS     = 4;
  localparam int DEFAULT_DATA_W     = 8;
  localparam int DEFAULT_FIFO_DEPTH = 4;
  localparam int ROW_COUNT_W        = 16;

  typedef logic [DEFAULT_N_COLS*DEFAULT_DATA_W-1:0] row_t;

  typedef struct packed {
    logic overflow;
    logic skew_err;
  } flags_t;

  // Index width for a power-of-two buffer; never narrower than one bit.
  function automatic int ptr_bits(input int depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/systolic_result_collector_result_fifo.sv
// Synchronous FIFO holding aligned result rows; the head entry is visible
// without a read request and reads as zero while empty.
module result_fifo
  import systolic_result_collector_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic             push_ok,
  output logic             drop
);

  localparam int AW = ptr_bits(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr_reg;
  logic [AW:0]      rd_ptr_reg;
  logic             pop_ok;

  // Extra pointer bit tells a full buffer from an empty one.
  assign empty   = (wr_ptr_reg == rd_ptr_reg);
  assign full    = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign drop    = push && full && !pop_ok;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else if (clear) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + {{AW{1'b0}}, 1'b1};
      if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + {{AW{1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok && !clear) mem[wr_ptr_reg[AW-1:0]] <= push_data;
  end

  assign pop_data = empty ? '0 : mem[rd_ptr_reg[AW-1:0]];

endmodule

// File: rtl/systolic_result_collector.sv
// De-skews the diagonal wavefront leaving the bottom PE row into whole
// result rows and buffers them for a ready/valid consumer.
module systolic_result_collector
  import systolic_result_collector_pkg::*;
#(
  parameter int N_COLS     = DEFAULT_N_COLS,
  parameter int DATA_W     = DEFAULT_DATA_W,
  parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic [N_COLS-1:0]        col_valid_in,
  input  logic [N_COLS*DATA_W-1:0] col_data_in,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [N_COLS*DATA_W-1:0] res_data,
  output logic [ROW_COUNT_W-1:0]   row_count,
  output logic                     overflow,
  output logic                     skew_err
);

  localparam int ROW_W = N_COLS * DATA_W;

  logic [N_COLS-1:0] aligned_valid;
  logic [ROW_W-1:0]  aligned_data;

  // Column c arrives c cycles late, so it gets c fewer stages than column 0.
  for (genvar gi = 0; gi < N_COLS; gi++) begin : g_col
    localparam int STAGES = N_COLS - gi;

    logic              valid_pipe_reg [STAGES];
    logic [DATA_W-1:0] data_pipe_reg  [STAGES];

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        for (int s = 0; s < STAGES; s++) begin
          valid_pipe_reg[s] <= 1'b0;
          data_pipe_reg[s]  <= '0;
        end
      end else if (clear) begin
        for (int s = 0; s < STAGES; s++) begin
          valid_pipe_reg[s] <= 1'b0;
          data_pipe_reg[s]  <= '0;
        end
      end else begin
        valid_pipe_reg[0] <= col_valid_in[gi];
        data_pipe_reg[0]  <= col_data_in[gi*DATA_W +: DATA_W];
        for (int s = 1; s < STAGES; s++) begin
          valid_pipe_reg[s] <= valid_pipe_reg[s-1];
          data_pipe_reg[s]  <= data_pipe_reg[s-1];
        end
      end
    end

    assign aligned_valid[gi]                 = valid_pipe_reg[STAGES-1];
    assign aligned_data[gi*DATA_W +: DATA_W] = data_pipe_reg[STAGES-1];
  end

  logic all_valid;
  logic any_valid;
  logic fifo_empty;
  logic fifo_full;
  logic push_ok;
  logic drop;
  logic pop;

  assign all_valid = &aligned_valid;
  assign any_valid = |aligned_valid;
  assign res_valid = !fifo_empty;
  assign pop       = res_valid && res_ready;

  result_fifo #(
    .WIDTH (ROW_W),
    .DEPTH (FIFO_DEPTH)
  ) u_result_fifo (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear),
    .push      (all_valid),
    .push_data (aligned_data),
    .pop       (pop),
    .pop_data  (res_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .push_ok   (push_ok),
    .drop      (drop)
  );

  flags_t                 flags_reg;
  flags_t                 flags_next;
  logic [ROW_COUNT_W-1:0] row_count_reg;
  logic [ROW_COUNT_W-1:0] row_count_next;

  always_comb begin
    flags_next     = flags_reg;
    row_count_next = row_count_reg;
    if (drop) flags_next.overflow = 1'b1;
    // A partial wavefront means an upstream column lost or gained a beat.
    if (any_valid && !all_valid) flags_next.skew_err = 1'b1;
    if (push_ok) row_count_next = row_count_reg + {{(ROW_COUNT_W-1){1'b0}}, 1'b1};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      flags_reg     <= '0;
      row_count_reg <= '0;
    end else if (clear) begin
      flags_reg     <= '0;
      row_count_reg <= '0;
    end else begin
      flags_reg     <= flags_next;
      row_count_reg <= row_count_next;
    end
  end

  assign row_count = row_count_reg;
  assign overflow  = flags_reg.overflow;
  assign skew_err  = flags_reg.skew_err;

  logic unused_full;
  assign unused_full = fifo_full;

endmodule

// File: tb/tb_systolic_result_collector.sv
// Directed bench for the result collector: a vector table drives the
// throughput test, short sequences cover overflow, skew, reset and clear.
module tb_systolic_result_collector;
  import systolic_result_collector_pkg::*;

  localparam int NC = 4;
  localparam int DW = 8;
  localparam int FD = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              clear;
  logic [NC-1:0]     col_valid_in;
  logic [NC*DW-1:0]  col_data_in;
  logic              res_valid;
  logic              res_ready;
  logic [NC*DW-1:0]  res_data;
  logic [15:0]       row_count;
  logic              overflow;
  logic              skew_err;

  always #5 clk = ~clk;

  systolic_result_collector #(
    .N_COLS     (NC),
    .DATA_W     (DW),
    .FIFO_DEPTH (FD)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .clear        (clear),
    .col_valid_in (col_valid_in),
    .col_data_in  (col_data_in),
    .res_valid    (res_valid),
    .res_ready    (res_ready),
    .res_data     (res_data),
    .row_count    (row_count),
    .overflow     (overflow),
    .skew_err     (skew_err)
  );

  typedef struct {
    logic [7:0] c0;
    logic [7:0] c1;
    logic [7:0] c2;
    logic [7:0] c3;
    row_t       exp;
  } vec_t;

  vec_t vecs [8];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int t0;
  int t1;

  // Launch table: row i presents column c on rising edge l_start[i] + c.
  int            n_launch = 0;
  int            l_start [16];
  row_t          l_row   [16];
  logic [NC-1:0] l_mask  [16];

  function automatic row_t vrow(input vec_t v);
    return {v.c3, v.c2, v.c1, v.c0};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end else begin
      $display("ok   %s at cycle %0d: %h", name, cyc, act);
    end
  endtask

  task automatic apply_inputs();
    logic [NC-1:0] v;
    row_t          d;
    int            e;
    e = cyc + 1;
    v = '0;
    d = '0;
    for (int i = 0; i < n_launch; i++)
      for (int c = 0; c < NC; c++)
        if ((e - l_start[i] == c) && l_mask[i][c]) begin
          v[c]            = 1'b1;
          d[c*DW +: DW]   = l_row[i][c*DW +: DW];
        end
    col_valid_in = v;
    col_data_in  = d;
  endtask

  // cyc counts rising edges; inputs set here are sampled on edge cyc+1.
  task automatic tick();
    @(negedge clk);
    cyc++;
    apply_inputs();
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) tick();
  endtask

  task automatic launch(input int start, input row_t row, input logic [NC-1:0] mask);
    l_start[n_launch] = start;
    l_row[n_launch]   = row;
    l_mask[n_launch]  = mask;
    n_launch++;
  endtask

  task automatic do_clear();
    n_launch = 0;
    clear    = 1'b1;
    tick();
    clear    = 1'b0;
  endtask

  initial begin
    vecs[0] = '{8'h11, 8'h22, 8'h33, 8'h44, 32'h44332211};
    vecs[1] = '{8'h00, 8'h00, 8'h00, 8'h00, 32'h00000000};
    vecs[2] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 32'hFFFFFFFF};
    vecs[3] = '{8'h01, 8'h02, 8'h04, 8'h08, 32'h08040201};
    vecs[4] = '{8'h80, 8'h40, 8'h20, 8'h10, 32'h10204080};
    vecs[5] = '{8'hA5, 8'h5A, 8'hC3, 8'h3C, 32'h3CC35AA5};
    vecs[6] = '{8'h7F, 8'h80, 8'hFE, 8'h01, 32'h01FE807F};
    vecs[7] = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 32'hEFBEADDE};

    rst          = 1'b0;
    clear        = 1'b0;
    res_ready    = 1'b0;
    col_valid_in = '0;
    col_data_in  = '0;
    tick();
    tick();
    check("rst_res_valid", 32'(res_valid), 32'd0);
    check("rst_res_data",  32'(res_data),  32'd0);
    check("rst_row_count", 32'(row_count), 32'd0);
    check("rst_overflow",  32'(overflow),  32'd0);
    check("rst_skew_err",  32'(skew_err),  32'd0);
    rst = 1'b1;
    tick();

    // Eight back-to-back rows with a ready consumer; first one is 11/22/33/44.
    do_clear();
    t0 = cyc;
    res_ready = 1'b1;
    for (int i = 0; i < 8; i++) launch(t0 + 10 + i, vrow(vecs[i]), 4'hF);
    wait_until(t0 + 13);
    check("latency_not_early", 32'(res_valid), 32'd0);
    for (int i = 0; i < 8; i++) begin
      wait_until(t0 + 14 + i);
      check($sformatf("stream_valid_%0d", i), 32'(res_valid), 32'd1);
      check($sformatf("stream_data_%0d", i),  32'(res_data),  vecs[i].exp);
      check($sformatf("stream_count_%0d", i), 32'(row_count), 32'(i + 1));
    end
    wait_until(t0 + 22);
    check("stream_drained",  32'(res_valid), 32'd0);
    check("stream_overflow", 32'(overflow),  32'd0);
    check("stream_skew",     32'(skew_err),  32'd0);

    // Six rows into a depth-4 buffer with the consumer stalled.
    do_clear();
    t0 = cyc;
    res_ready = 1'b0;
    for (int i = 0; i < 6; i++) launch(t0 + 10 + i, vrow(vecs[i]), 4'hF);
    wait_until(t0 + 17);
    check("full_no_overflow_yet", 32'(overflow), 32'd0);
    wait_until(t0 + 20);
    check("ovf_flag",  32'(overflow),  32'd1);
    check("ovf_count", 32'(row_count), 32'd4);
    check("ovf_valid", 32'(res_valid), 32'd1);
    res_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wait_until(t0 + 20 + i);
      check($sformatf("ovf_data_%0d", i), 32'(res_data), vecs[i].exp);
    end
    wait_until(t0 + 24);
    check("ovf_drained",     32'(res_valid), 32'd0);
    check("ovf_count_after", 32'(row_count), 32'd4);

    // Column 2 missing from one row, then a clean row.
    do_clear();
    check("clear_overflow", 32'(overflow), 32'd0);
    t0 = cyc;
    res_ready = 1'b0;
    launch(t0 + 10, vrow(vecs[0]), 4'b1011);
    launch(t0 + 16, vrow(vecs[1]), 4'hF);
    wait_until(t0 + 13);
    check("skew_before", 32'(skew_err), 32'd0);
    wait_until(t0 + 14);
    check("skew_set",   32'(skew_err),  32'd1);
    check("skew_valid", 32'(res_valid), 32'd0);
    check("skew_count", 32'(row_count), 32'd0);
    wait_until(t0 + 20);
    check("skew_next_valid",  32'(res_valid), 32'd1);
    check("skew_next_data",   32'(res_data),  vecs[1].exp);
    check("skew_next_count",  32'(row_count), 32'd1);
    check("skew_sticky",      32'(skew_err),  32'd1);

    // Full buffer; a new row aligns on the same edge as a pop.
    do_clear();
    t0 = cyc;
    res_ready = 1'b0;
    for (int i = 0; i < 4; i++) launch(t0 + 10 + i, vrow(vecs[2 + i]), 4'hF);
    launch(t0 + 15, vrow(vecs[6]), 4'hF);
    wait_until(t0 + 18);
    check("pp_head",  32'(res_data),  vecs[2].exp);
    check("pp_count", 32'(row_count), 32'd4);
    res_ready = 1'b1;
    for (int j = 1; j <= 4; j++) begin
      wait_until(t0 + 18 + j);
      check($sformatf("pp_data_%0d", j), 32'(res_data), vecs[2 + j].exp);
      if (j == 1) begin
        check("pp_count_after", 32'(row_count), 32'd5);
        check("pp_no_overflow", 32'(overflow),  32'd0);
      end
    end
    wait_until(t0 + 23);
    check("pp_drained",  32'(res_valid), 32'd0);
    check("pp_overflow", 32'(overflow),  32'd0);

    // Asynchronous reset with a row half-way through alignment.
    t0 = cyc;
    res_ready = 1'b0;
    n_launch = 0;
    launch(t0 + 10, vrow(vecs[7]), 4'hF);
    wait_until(t0 + 11);
    rst = 1'b0;
    n_launch = 0;
    apply_inputs();
    #1;
    check("arst_valid", 32'(res_valid), 32'd0);
    check("arst_data",  32'(res_data),  32'd0);
    check("arst_count", 32'(row_count), 32'd0);
    tick();
    rst = 1'b1;
    wait_until(t0 + 16);
    check("arst_no_partial", 32'(res_valid), 32'd0);
    check("arst_no_skew",    32'(skew_err),  32'd0);
    check("arst_count_hold", 32'(row_count), 32'd0);

    // Clear with two rows buffered drops them without a handshake.
    t1 = cyc;
    launch(t1 + 2, vrow(vecs[0]), 4'hF);
    launch(t1 + 3, vrow(vecs[1]), 4'hF);
    wait_until(t1 + 7);
    check("preclr_valid", 32'(res_valid), 32'd1);
    check("preclr_count", 32'(row_count), 32'd2);
    check("preclr_data",  32'(res_data),  vecs[0].exp);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("clr_valid",    32'(res_valid), 32'd0);
    check("clr_data",     32'(res_data),  32'd0);
    check("clr_count",    32'(row_count), 32'd0);
    check("clr_overflow", 32'(overflow),  32'd0);
    check("clr_skew",     32'(skew_err),  32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
